// File: rtl/uart_num_tx.sv
// Sends an 8-bit unsigned value as decimal ASCII text (leading zeros suppressed) followed by
// CR LF over an 8N1 UART line, LSB first.
module uart_num_tx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_tx
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam logic [15:0] BitLast  = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  char_q, char_d;
  logic [7:0]  val_q, val_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0] hund, tens, ones;
  logic [7:0] cur_char;
  logic [2:0] first_idx;
  logic       bit_end;

  assign hund    = val_q / 8'd100;
  assign tens    = (val_q / 8'd10) % 8'd10;
  assign ones    = val_q % 8'd10;
  assign bit_end = (cnt_q == BitLast);

  // Character slots are fixed as H, T, O, CR, LF; short numbers just start further in.
  always_comb begin
    unique case (char_q)
      3'd0:    cur_char = 8'h30 + hund;
      3'd1:    cur_char = 8'h30 + tens;
      3'd2:    cur_char = 8'h30 + ones;
      3'd3:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  always_comb begin
    if (tx_data >= 8'd100) begin
      first_idx = 3'd0;
    end else if (tx_data >= 8'd10) begin
      first_idx = 3'd1;
    end else begin
      first_idx = 3'd2;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    char_d  = char_q;
    val_d   = val_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start && !busy_q) begin
          state_d = StStart;
          val_d   = tx_data;
          char_d  = first_idx;
          cnt_d   = 16'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = 16'd0;
          bit_d   = 3'd0;
          tx_d    = cur_char[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_char[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = 16'd0;
          // Zero-cycle NEXT decision: either chain straight into the next start bit or finish.
          if (char_q == 3'd4) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            state_d = StStart;
            char_d  = char_q + 3'd1;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      char_q  <= 3'd0;
      val_q   <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      val_q   <= val_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign uart_tx = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
